difftest_commit_checker: RTL and testbench
==========================================

// Module: difftest_commit_checker
// PURPOSE
//   Consumer end of the core's difftest commit stream (diff_enable/diff_PC/diff_Instr/nextPC).
//   - Checks PC continuity: each commit's PC must equal the previous commit's nextPC.
//   - Detects ebreak (halt) and commit starvation (hang).
//   - Keeps an itrace ring of the last DEPTH commits, readable by the sim harness after a stop.
//   Sits in the sim top beside the core; consumes the registered difftest outputs.
// PARAMETERS
//   DATA_WIDTH  32            PC/instruction width
//   DEPTH       16            itrace ring entries; power of 2, >= 2
//   TIMEOUT     1024          consecutive commit-free cycles that declare a hang
//   RESET_PC    32'h8000_0000 required PC of the first commit
// PORTS
//   clk          in   1              clock
//   rst          in   1              reset: synchronous, active-high
//   diff_enable  in   1              commit valid this cycle
//   diff_PC      in   DATA_WIDTH     PC of committing instruction
//   diff_Instr   in   DATA_WIDTH     committing instruction word
//   nextPC       in   DATA_WIDTH     PC the core will commit next
//   rd_req       in   1              itrace read request
//   rd_idx       in   $clog2(DEPTH)  0 = newest entry, k = k-th older
//   rd_valid     out  1              read data valid (registered)
//   rd_PC        out  DATA_WIDTH     read entry PC
//   rd_Instr     out  DATA_WIDTH     read entry instruction
//   state        out  2              00 WAIT_FIRST, 01 RUN, 10 HALT, 11 ERROR
//   commit_cnt   out  64             accepted commits (wraps at 2^64)
//   pc_mismatch  out  1              sticky: continuity error
//   timeout      out  1              sticky: hang detected
//   err_PC       out  DATA_WIDTH     PC of offending commit
//   err_expPC    out  DATA_WIDTH     PC that was expected
// BEHAVIOUR
//   Reset: state=WAIT_FIRST, exp_pc=RESET_PC, commit_cnt=0, idle_cnt=0, wr_ptr=0, fill=0.
//     All outputs 0; ring contents don't-care (unreadable since fill=0). rst mid-run returns here.
//   Accepted commit: diff_enable=1 while state is WAIT_FIRST or RUN. Per accepted commit:
//     - ring[wr_ptr] <= {diff_PC, diff_Instr}; wr_ptr wraps mod DEPTH; fill saturates at DEPTH.
//     - commit_cnt += 1; idle_cnt <= 0.
//     - diff_PC != exp_pc: next state ERROR; pc_mismatch=1; err_PC=diff_PC; err_expPC=exp_pc.
//       Offending commit is still recorded and counted.
//     - Else exp_pc <= nextPC:
//       diff_Instr == 32'h0010_0073 (ebreak) -> HALT;
//       else WAIT_FIRST -> RUN, RUN stays RUN.
//     - Mismatch and ebreak on the same commit: ERROR wins.
//   Hang: in WAIT_FIRST/RUN, each cycle without diff_enable increments idle_cnt.
//     - Cycle where idle_cnt == TIMEOUT-1 and no commit: next state ERROR; timeout=1;
//       err_PC=0; err_expPC=exp_pc.
//     - A commit in that same cycle wins: idle_cnt cleared, no timeout.
//   HALT and ERROR are terminal until rst:
//     - commits ignored; commit_cnt, ring, flags, err_* frozen; idle_cnt frozen.
//   Readout, one-cycle latency, served in any state:
//     - rd_req at edge t -> at t+1: rd_valid = (rd_idx < fill);
//       rd_PC/rd_Instr = ring[(wr_ptr-1-rd_idx) mod DEPTH] if valid, else 0.
//     - No rd_req -> rd_valid=0; rd_PC/rd_Instr hold their previous values.
//     - Read and commit at the same edge: read uses pre-write wr_ptr/fill and returns old contents.
//   Ring is single-write, single-read registers; no other combinational path from inputs to outputs.
// TESTING
//   Reset then commits 80000000/00000013/nextPC 80000004, then 80000004 -> state=01, commit_cnt=2, no flags.
//   First commit PC=80000010 -> state=11, pc_mismatch=1, err_PC=80000010, err_expPC=80000000, commit_cnt=1.
//   Jump commit 80000008/nextPC 80000100, then 80000100/00100073 -> state=10; further commits leave commit_cnt unchanged.
//   Idle TIMEOUT=8 after 1 commit -> timeout=1 visible the cycle after the 8th idle cycle;
//     commit on the 8th idle cycle -> no timeout.
//   20 commits, DEPTH=16, rd_idx=0 -> 20th entry; rd_idx=15 -> 5th entry; 3 commits, rd_idx=3 -> rd_valid=0, data 0.
//   Assert rst mid-RUN with fill=5 -> state=00, commit_cnt=0, flags=0, rd_idx=0 read -> rd_valid=0.

Source files
------------

// File: rtl/difftest_commit_checker.sv
// difftest_commit_checker
//   Consumer end of the core's difftest commit stream. Checks that each
//   commit's PC follows the previous commit's nextPC, detects ebreak (halt)
//   and commit starvation (hang), and keeps an itrace ring of the last DEPTH
//   commits that the sim harness can read back after a stop.
// Ports
//   clk, rst                          clock, synchronous active-high reset
//   diff_enable/diff_PC/diff_Instr    commit stream from the core
//   nextPC                            PC the core will commit next
//   rd_req/rd_idx                     itrace read (0 = newest entry)
//   rd_valid/rd_PC/rd_Instr           registered read result
//   state                             00 WAIT_FIRST, 01 RUN, 10 HALT, 11 ERROR
//   commit_cnt                        accepted commits
//   pc_mismatch/timeout               sticky error flags
//   err_PC/err_expPC                  offending PC and the PC that was expected
module difftest_commit_checker #(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           DEPTH      = 16,
  parameter int unsigned           TIMEOUT    = 1024,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = 32'h8000_0000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     diff_enable,
  input  logic [DATA_WIDTH-1:0]    diff_PC,
  input  logic [DATA_WIDTH-1:0]    diff_Instr,
  input  logic [DATA_WIDTH-1:0]    nextPC,
  input  logic                     rd_req,
  input  logic [$clog2(DEPTH)-1:0] rd_idx,
  output logic                     rd_valid,
  output logic [DATA_WIDTH-1:0]    rd_PC,
  output logic [DATA_WIDTH-1:0]    rd_Instr,
  output logic [1:0]               state,
  output logic [63:0]              commit_cnt,
  output logic                     pc_mismatch,
  output logic                     timeout,
  output logic [DATA_WIDTH-1:0]    err_PC,
  output logic [DATA_WIDTH-1:0]    err_expPC
);

  localparam int unsigned           AW        = $clog2(DEPTH);
  localparam int unsigned           IW        = $clog2(TIMEOUT) + 1;
  localparam logic [IW-1:0]         IDLE_LAST = IW'(TIMEOUT - 1);
  localparam logic [AW:0]           FILL_MAX  = (AW + 1)'(DEPTH);
  localparam logic [DATA_WIDTH-1:0] EBREAK    = DATA_WIDTH'(32'h0010_0073);

  typedef enum logic [1:0] {
    WAIT_FIRST = 2'b00,
    RUN        = 2'b01,
    HALT       = 2'b10,
    ERROR      = 2'b11
  } state_t;

  state_t                  cur, nxt;
  logic [DATA_WIDTH-1:0]   exp_pc;
  logic [IW-1:0]           idle_cnt;
  logic [AW-1:0]           wr_ptr;
  logic [AW:0]             fill;
  logic [DATA_WIDTH-1:0]   ring_pc    [DEPTH];
  logic [DATA_WIDTH-1:0]   ring_instr [DEPTH];

  logic                    live, accept, pc_bad, hang, rd_hit;
  logic [AW-1:0]           rd_slot;

  assign state = cur;

  always_comb begin
    live    = (cur == WAIT_FIRST) || (cur == RUN);
    accept  = live && diff_enable;
    pc_bad  = diff_PC != exp_pc;
    hang    = live && !diff_enable && (idle_cnt == IDLE_LAST);
    // Slot arithmetic wraps mod DEPTH because DEPTH is a power of two.
    rd_slot = wr_ptr - AW'(1) - rd_idx;
    rd_hit  = {1'b0, rd_idx} < fill;

    nxt = cur;
    if (accept) begin
      // Mismatch takes priority over ebreak on the same commit.
      if (pc_bad)                     nxt = ERROR;
      else if (diff_Instr == EBREAK)  nxt = HALT;
      else                            nxt = RUN;
    end else if (hang) begin
      nxt = ERROR;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cur <= WAIT_FIRST;
    else     cur <= nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      exp_pc      <= RESET_PC;
      idle_cnt    <= '0;
      wr_ptr      <= '0;
      fill        <= '0;
      commit_cnt  <= '0;
      pc_mismatch <= 1'b0;
      timeout     <= 1'b0;
      err_PC      <= '0;
      err_expPC   <= '0;
      rd_valid    <= 1'b0;
      rd_PC       <= '0;
      rd_Instr    <= '0;
    end else begin
      if (accept) begin
        commit_cnt <= commit_cnt + 64'd1;
        idle_cnt   <= '0;
        wr_ptr     <= wr_ptr + AW'(1);
        if (fill != FILL_MAX) fill <= fill + (AW + 1)'(1);
        if (pc_bad) begin
          pc_mismatch <= 1'b1;
          err_PC      <= diff_PC;
          err_expPC   <= exp_pc;
        end else begin
          exp_pc <= nextPC;
        end
      end else if (live) begin
        if (hang) begin
          timeout   <= 1'b1;
          err_PC    <= '0;
          err_expPC <= exp_pc;
        end else begin
          idle_cnt <= idle_cnt + IW'(1);
        end
      end

      // Read uses pre-write pointer/fill, so a same-edge commit is not visible.
      if (rd_req) begin
        rd_valid <= rd_hit;
        rd_PC    <= rd_hit ? ring_pc[rd_slot]    : '0;
        rd_Instr <= rd_hit ? ring_instr[rd_slot] : '0;
      end else begin
        rd_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && accept) begin
      ring_pc[wr_ptr]    <= diff_PC;
      ring_instr[wr_ptr] <= diff_Instr;
    end
  end

endmodule

// File: tb/tb_difftest_commit_checker.sv
module tb_difftest_commit_checker;

  localparam int DW  = 32;
  localparam int DEP = 16;
  localparam int TO  = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          diff_enable = 1'b0;
  logic [DW-1:0] diff_PC = '0, diff_Instr = '0, nextPC = '0;
  logic          rd_req = 1'b0;
  logic [3:0]    rd_idx = '0;
  logic          rd_valid;
  logic [DW-1:0] rd_PC, rd_Instr;
  logic [1:0]    state;
  logic [63:0]   commit_cnt;
  logic          pc_mismatch, timeout;
  logic [DW-1:0] err_PC, err_expPC;

  difftest_commit_checker #(
    .DATA_WIDTH(DW),
    .DEPTH(DEP),
    .TIMEOUT(TO),
    .RESET_PC(32'h8000_0000)
  ) dut (
    .clk(clk), .rst(rst),
    .diff_enable(diff_enable), .diff_PC(diff_PC), .diff_Instr(diff_Instr), .nextPC(nextPC),
    .rd_req(rd_req), .rd_idx(rd_idx),
    .rd_valid(rd_valid), .rd_PC(rd_PC), .rd_Instr(rd_Instr),
    .state(state), .commit_cnt(commit_cnt),
    .pc_mismatch(pc_mismatch), .timeout(timeout),
    .err_PC(err_PC), .err_expPC(err_expPC)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Behavioural model: history kept newest-first, states as plain codes.
  logic [63:0]   m_hist[$];
  int            m_state;
  longint unsigned m_cnt;
  int            m_idle;
  logic [DW-1:0] m_exp;
  logic          m_mis, m_to;
  logic [DW-1:0] m_errpc, m_errexp;
  logic          m_rv;
  logic [DW-1:0] m_rpc, m_rinstr;
  bit            m_known = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic model_edge();
    bit live;
    if (rst) begin
      m_known = 1;
      m_hist.delete();
      m_state = 0; m_cnt = 0; m_idle = 0; m_exp = 32'h8000_0000;
      m_mis = 0; m_to = 0; m_errpc = '0; m_errexp = '0;
      m_rv = 0; m_rpc = '0; m_rinstr = '0;
      return;
    end
    if (rd_req) begin
      m_rv = int'(rd_idx) < m_hist.size();
      m_rpc    = m_rv ? m_hist[rd_idx][63:32] : '0;
      m_rinstr = m_rv ? m_hist[rd_idx][31:0]  : '0;
    end else begin
      m_rv = 0;
    end
    live = (m_state == 0) || (m_state == 1);
    if (!live) return;
    if (diff_enable) begin
      m_hist.push_front({diff_PC, diff_Instr});
      if (m_hist.size() > DEP) void'(m_hist.pop_back());
      m_cnt++;
      m_idle = 0;
      if (diff_PC != m_exp) begin
        m_state = 3; m_mis = 1; m_errpc = diff_PC; m_errexp = m_exp;
      end else begin
        m_exp = nextPC;
        m_state = (diff_Instr == 32'h0010_0073) ? 2 : 1;
      end
    end else if (m_idle == TO - 1) begin
      m_state = 3; m_to = 1; m_errpc = '0; m_errexp = m_exp;
    end else begin
      m_idle++;
    end
  endtask

  task automatic compare_all();
    if (!m_known) return;
    chk("state",       64'(state),       64'(m_state));
    chk("commit_cnt",  commit_cnt,       m_cnt);
    chk("pc_mismatch", 64'(pc_mismatch), 64'(m_mis));
    chk("timeout",     64'(timeout),     64'(m_to));
    chk("err_PC",      64'(err_PC),      64'(m_errpc));
    chk("err_expPC",   64'(err_expPC),   64'(m_errexp));
    chk("rd_valid",    64'(rd_valid),    64'(m_rv));
    chk("rd_PC",       64'(rd_PC),       64'(m_rpc));
    chk("rd_Instr",    64'(rd_Instr),    64'(m_rinstr));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycle();
    cycle();
    rst = 1'b0;
  endtask

  task automatic commit(input logic [DW-1:0] pc, input logic [DW-1:0] ins, input logic [DW-1:0] npc);
    diff_enable = 1'b1; diff_PC = pc; diff_Instr = ins; nextPC = npc;
    cycle();
    diff_enable = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) cycle();
  endtask

  task automatic rd(input logic [3:0] idx);
    rd_req = 1'b1; rd_idx = idx;
    cycle();
    rd_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    do_reset();
    chk("lit_reset_state", 64'(state), 64'd0);
    chk("lit_reset_cnt", commit_cnt, 64'd0);

    // Sequential run, then jump and ebreak
    commit(32'h8000_0000, 32'h0000_0013, 32'h8000_0004);
    commit(32'h8000_0004, 32'h0000_0013, 32'h8000_0008);
    chk("lit_run_state", 64'(state), 64'd1);
    chk("lit_run_cnt", commit_cnt, 64'd2);
    chk("lit_run_flags", 64'({pc_mismatch, timeout}), 64'd0);
    commit(32'h8000_0008, 32'h0000_006f, 32'h8000_0100);
    commit(32'h8000_0100, 32'h0010_0073, 32'h8000_0104);
    chk("lit_halt_state", 64'(state), 64'd2);
    commit(32'h8000_0104, 32'h0000_0013, 32'h8000_0108);
    commit(32'h8000_0108, 32'h0000_0013, 32'h8000_010c);
    chk("lit_halt_cnt_frozen", commit_cnt, 64'd4);

    // First commit at the wrong PC
    do_reset();
    commit(32'h8000_0010, 32'h0000_0013, 32'h8000_0014);
    chk("lit_mis_state", 64'(state), 64'd3);
    chk("lit_mis_flag", 64'(pc_mismatch), 64'd1);
    chk("lit_mis_errpc", 64'(err_PC), 64'h8000_0010);
    chk("lit_mis_errexp", 64'(err_expPC), 64'h8000_0000);
    chk("lit_mis_cnt", commit_cnt, 64'd1);
    commit(32'h8000_0014, 32'h0000_0013, 32'h8000_0018);
    idle(3);

    // Mismatch and ebreak on the same commit: ERROR wins
    do_reset();
    commit(32'h8000_0020, 32'h0010_0073, 32'h8000_0024);
    chk("lit_mis_ebreak_state", 64'(state), 64'd3);

    // Hang detection
    do_reset();
    commit(32'h8000_0000, 32'h0000_0013, 32'h8000_0004);
    idle(TO - 1);
    chk("lit_to_not_yet", 64'(timeout), 64'd0);
    idle(1);
    chk("lit_to_flag", 64'(timeout), 64'd1);
    chk("lit_to_state", 64'(state), 64'd3);
    chk("lit_to_errexp", 64'(err_expPC), 64'h8000_0004);
    idle(2);

    // Commit on the last idle cycle cancels the hang
    do_reset();
    commit(32'h8000_0000, 32'h0000_0013, 32'h8000_0004);
    idle(TO - 1);
    commit(32'h8000_0004, 32'h0000_0013, 32'h8000_0008);
    chk("lit_to_saved", 64'(timeout), 64'd0);
    chk("lit_to_saved_state", 64'(state), 64'd1);
    idle(TO);
    chk("lit_to_late", 64'(err_expPC), 64'h8000_0008);

    // Ring readout after 20 commits
    do_reset();
    for (int i = 0; i < 20; i++)
      commit(32'h8000_0000 + 32'(4 * i), 32'h0000_0013 + 32'(i << 7), 32'h8000_0004 + 32'(4 * i));
    rd(4'd0);
    chk("lit_rd0_valid", 64'(rd_valid), 64'd1);
    chk("lit_rd0_pc", 64'(rd_PC), 64'h8000_004c);
    rd(4'd15);
    chk("lit_rd15_pc", 64'(rd_PC), 64'h8000_0010);
    idle(1);
    chk("lit_rd_hold", 64'(rd_PC), 64'h8000_0010);
    // Same-edge read and commit returns the previous newest entry
    rd_req = 1'b1; rd_idx = 4'd0;
    commit(32'h8000_0050, 32'h0000_0013, 32'h8000_0054);
    rd_req = 1'b0;
    chk("lit_rd_same_edge", 64'(rd_PC), 64'h8000_004c);
    rd(4'd0);
    chk("lit_rd_after", 64'(rd_PC), 64'h8000_0050);

    // Partially filled ring
    do_reset();
    for (int i = 0; i < 3; i++)
      commit(32'h8000_0000 + 32'(4 * i), 32'h0000_0013, 32'h8000_0004 + 32'(4 * i));
    rd(4'd3);
    chk("lit_rd3_valid", 64'(rd_valid), 64'd0);
    chk("lit_rd3_data", 64'(rd_PC), 64'd0);
    rd(4'd2);
    chk("lit_rd2_pc", 64'(rd_PC), 64'h8000_0000);

    // Reset mid-run
    do_reset();
    for (int i = 0; i < 5; i++)
      commit(32'h8000_0000 + 32'(4 * i), 32'h0000_0013, 32'h8000_0004 + 32'(4 * i));
    do_reset();
    chk("lit_rst_state", 64'(state), 64'd0);
    chk("lit_rst_cnt", commit_cnt, 64'd0);
    rd(4'd0);
    chk("lit_rst_rd_valid", 64'(rd_valid), 64'd0);
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
